// File: rtl/stack_pkg.sv
// Shared stack definitions: word/pointer widths and the drain controller state encoding.
package stack_pkg;

  localparam int unsigned STK_DATA_W = 8;
  localparam int unsigned STK_CNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_OFFER  = 3'd3,
    ST_FINISH = 3'd4
  } drain_state_e;

  // Bits needed to hold a down-count from lat-1 to zero; never narrower than one bit.
  function automatic int unsigned lat_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/stack_drain_if.sv
// Stack-side pop port plus the valid/ready output port of the drain controller.
interface stack_drain_if
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = STK_DATA_W
);

  logic              stk_pop;
  logic [DATA_W-1:0] stk_data;
  logic              stk_error;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output stk_pop,
    output out_data,
    output out_valid,
    input  stk_data,
    input  stk_error,
    input  out_ready
  );

  modport slave (
    input  stk_pop,
    input  out_data,
    input  out_valid,
    output stk_data,
    output stk_error,
    output out_ready
  );

endinterface

// File: rtl/stack_drain_lat.sv
// Pop-latency down-counter: load on pop, decrement while waiting, zero flags the sample cycle.
module stack_drain_lat #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stack_drain.sv
// Drains the LIFO stack on a start pulse, offering each popped word on a valid/ready port
// until the stack reports empty or MAX_WORDS words have been delivered.
module stack_drain
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W    = STK_DATA_W,
  parameter int unsigned CNT_W     = STK_CNT_W,
  parameter int unsigned MAX_WORDS = 32,
  parameter int unsigned POP_LAT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  stack_drain_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W:0]      word_cnt
);

  localparam int unsigned     LatW    = lat_width(POP_LAT);
  localparam logic [LatW-1:0] LatLoad = LatW'(POP_LAT - 1);
  localparam logic [CNT_W:0]  MaxCnt  = (CNT_W + 1)'(MAX_WORDS);

  drain_state_e state_q, state_d;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W:0]    word_cnt_q, word_cnt_d;
  logic [CNT_W:0]    cnt_inc;
  logic              lat_zero;
  logic              accept;
  logic              last_word;

  stack_drain_lat #(
    .Width (LatW)
  ) u_lat (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (state_q == ST_POP),
    .load_val_i (LatLoad),
    .dec_i      (state_q == ST_WAIT),
    .zero_o     (lat_zero)
  );

  assign accept    = out_valid_q & bus.out_ready;
  assign cnt_inc   = word_cnt_q + 1'b1;
  assign last_word = (cnt_inc == MaxCnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_POP;
      ST_POP:    state_d = ST_WAIT;
      ST_WAIT: begin
        // Error on the sample cycle means the pop found the stack empty.
        if (lat_zero) state_d = bus.stk_error ? ST_FINISH : ST_OFFER;
      end
      ST_OFFER:  if (accept) state_d = last_word ? ST_FINISH : ST_POP;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.stk_pop = (state_q == ST_POP);
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_FINISH);
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q;
    unique case (state_q)
      ST_IDLE: if (start) word_cnt_d = '0;
      ST_WAIT: begin
        if (lat_zero && !bus.stk_error) begin
          out_data_d  = bus.stk_data;
          out_valid_d = 1'b1;
        end
      end
      ST_OFFER: begin
        if (accept) begin
          out_valid_d = 1'b0;
          word_cnt_d  = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_stack_drain.sv
// Bench for stack_drain: queue-based LIFO model with POP_LAT=2 response delay, table vectors,
// random drains, and hand sequences for stall, restart, done-cycle start and reset corners.
module tb_stack_drain;
  import stack_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 5;
  localparam int unsigned MAXW = 4;
  localparam int unsigned LAT  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [CW:0]   word_cnt;

  stack_drain_if #(.DATA_W(DW)) bus ();

  stack_drain #(
    .DATA_W    (DW),
    .CNT_W     (CW),
    .MAX_WORDS (MAXW),
    .POP_LAT   (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LIFO model; back of the queue is the top of stack. Response appears LAT=2 cycles after pop.
  logic [DW-1:0] stk[$];
  logic [DW-1:0] d1_data = '0, d2_data = '0;
  logic          d1_err = 1'b0, d2_err = 1'b0;
  logic          inj_err = 1'b0;
  logic          rdy = 1'b0;

  always @(posedge clk) begin
    if (bus.stk_pop) begin
      if (stk.size() == 0) begin
        d1_err <= 1'b1;
      end else begin
        d1_err  <= 1'b0;
        d1_data <= stk.pop_back();
      end
    end
    d2_data <= d1_data;
    d2_err  <= d1_err;
  end

  assign bus.stk_data  = d2_data;
  assign bus.stk_error = d2_err | inj_err;
  assign bus.out_ready = rdy;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop/accept/done bookkeeping plus handshake stability checks.
  int            pop_cnt = 0, done_cnt = 0, done_wc = 0, done_cyc = 0, first_pop_cyc = -1;
  logic [DW-1:0] got[$];
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (bus.stk_pop) begin
        pop_cnt++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      if (bus.out_valid) chk("no_pop_while_valid", {31'd0, bus.stk_pop}, 32'd0);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_data", {24'd0, bus.out_data}, {24'd0, prev_data});
      end
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      if (done) begin
        done_cnt++;
        done_wc  = int'(word_cnt);
        done_cyc = cyc;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  function automatic int exp_cnt_of(input int n);
    return (n < int'(MAXW)) ? n : int'(MAXW);
  endfunction

  // An under-limit drain needs one extra pop to discover the stack is empty.
  function automatic int exp_pops_of(input int n);
    return (n < int'(MAXW)) ? n + 1 : int'(MAXW);
  endfunction

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) stk.push_back(DW'($urandom_range(0, 255)));
  endtask

  task automatic pulse_start(output int s_cyc);
    @(posedge clk); #1;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_pop"},   {31'd0, bus.stk_pop},   32'd0);
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({nm, "_data"},  {24'd0, bus.out_data},  32'd0);
    chk({nm, "_busy"},  {31'd0, busy},          32'd0);
    chk({nm, "_done"},  {31'd0, done},          32'd0);
    chk({nm, "_cnt"},   {26'd0, word_cnt},      32'd0);
  endtask

  task automatic drain(input string nm, input int rdy_pct, input int exp_cnt, input int exp_pops,
                       input bit restart, output int s_cyc);
    logic [DW-1:0] exp_w[$];
    int k, rem;
    bit to;
    k = (stk.size() < int'(MAXW)) ? stk.size() : int'(MAXW);
    for (int i = 0; i < k; i++) exp_w.push_back(stk[stk.size() - 1 - i]);
    rem = stk.size() - k;
    got.delete();
    pop_cnt = 0;
    done_cnt = 0;
    first_pop_cyc = -1;
    rdy = ($urandom_range(0, 99) < rdy_pct);
    pulse_start(s_cyc);
    to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rdy   = ($urandom_range(0, 99) < rdy_pct);
      start = restart && (c == 1);
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
    chk({nm, "_timeout"}, {31'd0, to}, 32'd0);
    chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_nwords"}, got.size(), k);
    for (int i = 0; i < k && i < got.size(); i++)
      chk({nm, "_word"}, {24'd0, got[i]}, {24'd0, exp_w[i]});
    chk({nm, "_pops"}, pop_cnt, exp_pops);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_done_wc"}, done_wc, exp_cnt);
    chk({nm, "_wc_held"}, {26'd0, word_cnt}, exp_cnt);
    chk({nm, "_stack_left"}, stk.size(), rem);
  endtask

  typedef struct {
    int n_push;
    int rdy_pct;
    int exp_cnt;
    int exp_pops;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int s_cyc, n, p, base_pops;
    bit seen;

    tbl[0] = '{0, 100, 0, 1};
    tbl[1] = '{1, 100, 1, 2};
    tbl[2] = '{3, 100, 3, 4};
    tbl[3] = '{4, 100, 4, 4};
    tbl[4] = '{6, 50, 4, 4};
    tbl[5] = '{2, 30, 2, 3};

    #2;
    check_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Known-order drain of three words.
    stk.delete();
    stk.push_back(8'h11); stk.push_back(8'h22); stk.push_back(8'h33);
    drain("t1", 100, 3, 4, 1'b0, s_cyc);
    if (got.size() == 3) begin
      chk("t1_first", {24'd0, got[0]}, 32'h33);
      chk("t1_last", {24'd0, got[2]}, 32'h11);
    end

    // Empty stack: one pop, nothing offered, fixed done latency.
    stk.delete();
    drain("t2", 100, 0, 1, 1'b0, s_cyc);
    chk("t2_pop_lat", first_pop_cyc - s_cyc, 1);
    chk("t2_done_lat", done_cyc - s_cyc, LAT + 2);

    // Full stack capped at MAX_WORDS.
    stk.delete();
    push_rand(32);
    drain("t3", 100, 4, 4, 1'b0, s_cyc);
    chk("t3_left28", stk.size(), 28);

    for (int i = 0; i < 6; i++) begin
      stk.delete();
      push_rand(tbl[i].n_push);
      drain($sformatf("tbl%0d", i), tbl[i].rdy_pct, tbl[i].exp_cnt, tbl[i].exp_pops, 1'b0, s_cyc);
    end

    // Stall for 10 cycles with a spurious stack error, then accept.
    stk.delete();
    stk.push_back(8'hA5); stk.push_back(8'h5A);
    got.delete(); pop_cnt = 0; done_cnt = 0;
    rdy = 1'b0;
    pulse_start(s_cyc);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.out_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("t4_valid_seen", {31'd0, seen}, 32'd1);
    p = pop_cnt;
    inj_err = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t4_hold_data", {24'd0, bus.out_data}, 32'h5A);
    end
    chk("t4_no_pop", pop_cnt, p);
    rdy = 1'b1;
    @(posedge clk); #1;
    inj_err = 1'b0;
    chk("t4_pop_after_acc", {31'd0, bus.stk_pop}, 32'd1);
    chk("t4_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    for (int c = 0; c < 50 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
    end
    chk("t4_done", done_cnt, 1);
    chk("t4_nwords", got.size(), 2);
    if (got.size() == 2) chk("t4_second", {24'd0, got[1]}, 32'hA5);
    chk("t4_wc", {26'd0, word_cnt}, 32'd2);
    chk("t4_pops", pop_cnt, 3);

    // Start pulse while busy is ignored.
    stk.delete();
    push_rand(5);
    drain("t5_busy", 100, 4, 4, 1'b1, s_cyc);
    stk.delete();
    push_rand(2);
    drain("t5_busy_short", 70, 2, 3, 1'b1, s_cyc);

    // Start during the done cycle is ignored.
    stk.delete();
    push_rand(1);
    rdy = 1'b1;
    pulse_start(s_cyc);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done) begin start = 1'b1; seen = 1'b1; break; end
    end
    chk("t5_done_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    p = pop_cnt;
    for (int i = 0; i < 3; i++) begin
      chk("t5_done_start_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    chk("t5_done_start_pops", pop_cnt, p);

    // Reset mid-WAIT.
    stk.delete();
    push_rand(3);
    rdy = 1'b1;
    pulse_start(s_cyc);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_zero("t6_wait");
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset mid-OFFER after one word accepted.
    stk.delete();
    push_rand(3);
    rdy = 1'b0;
    base_pops = 0;
    pulse_start(s_cyc);
    for (int c = 0; c < 30 && !bus.out_valid; c++) begin
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    for (int c = 0; c < 30 && !bus.out_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("t6_offer_cnt1", {26'd0, word_cnt}, 32'd1);
    reset = 1'b1;
    #1;
    check_zero("t6_offer");
    @(posedge clk); #1;
    reset = 1'b0;
    n = stk.size();
    drain("t6_after", 100, exp_cnt_of(n), exp_pops_of(n), 1'b0, s_cyc);

    // Random drains against the model.
    for (int it = 0; it < 20; it++) begin
      if (stk.size() > 20) stk.delete();
      push_rand($urandom_range(0, 7));
      n = stk.size();
      drain($sformatf("rnd%0d", it), $urandom_range(20, 100), exp_cnt_of(n), exp_pops_of(n),
            1'($urandom_range(0, 1)), s_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
